gpio_led_ctrl: RTL
==================

GPIO_LED_CTRL -- requirements
Module: gpio_led_ctrl

Interface
REQ-001 SHALL have parameter NB_GPIOS, default 32, GPIO word width (min 32).
REQ-002 SHALL have parameter N_RGB, default 4, number of RGB LEDs; N_RGB*3 <= 16.
REQ-003 SHALL have parameter NB_LEDS, default 4, plain LED count (<= 16).
REQ-004 SHALL have parameter NB_SWITCHES, default 4, switch count (<= 16).
REQ-005 SHALL have parameter NB_PWM, default 8, PWM resolution in bits (<= 16).
REQ-006 SHALL have parameter DEBOUNCE_CYC, default 1000000, switch stability window in cycles (>= 2).
REQ-007 SHALL have parameter NB_BLINK, default 24, blink prescaler width.
REQ-008 SHALL have port i_clk, input, 1, the only clock.
REQ-009 SHALL have port i_reset, input, 1, reset, synchronous, active-low.
REQ-010 SHALL have port i_gpo, input, NB_GPIOS, command word from the processor.
REQ-011 SHALL have port o_gpi, output, NB_GPIOS, status word to the processor.
REQ-012 SHALL have port i_sw, input, NB_SWITCHES, raw asynchronous switches.
REQ-013 SHALL have port o_leds_rgb, output, 3*N_RGB, PWM RGB outputs; bit 3k+c is LED k, colour c.
REQ-014 SHALL have port o_leds, output, NB_LEDS, plain LED outputs.

Function
REQ-015 SHALL decode i_gpo as strobe [31], opcode [30:28], channel [27:24] and data [NB_PWM-1:0].
REQ-016 SHALL accept a command only on a 0->1 transition of i_gpo[31], detected against the previous-cycle registered value.
REQ-017 SHALL apply the command's effect on the cycle after detection.
- Cycle 1: edge seen.
- Cycle 2: registers updated.
REQ-018 SHALL implement the opcodes as follows; anything else is invalid.
- 0 NOP.
- 1 SET_DUTY: duty[channel] = data; channel < 3*N_RGB.
- 2 SET_LED: led_val[channel] = data[0]; channel < NB_LEDS.
- 3 SET_BLINK: blink_en[channel] = data[0]; channel < NB_LEDS.
- 4 CLEAR_ALL: all duty, led_val and blink_en to 0; error flag cleared.
REQ-019 SHALL treat an invalid opcode, or a channel out of range, as a no-op on LED state and set the sticky error flag.
REQ-020 SHALL drive o_gpi as follows.
- [31] ack: equals the registered strobe level, updated in the same cycle the command takes effect.
- [30] sticky error flag.
- [23:16] accepted-command count, 8-bit, wrapping 255->0, counting invalid commands too.
- [NB_SWITCHES-1:0] debounced switches.
- All other bits 0.
REQ-021 SHALL run a free-running PWM counter from 0 to 2^NB_PWM-2, then wrap to 0 (period 2^NB_PWM-1 cycles).
REQ-022 SHALL drive each RGB output high iff counter < duty, registered.
- duty 0: constant low.
- duty 2^NB_PWM-1: constant high.
REQ-023 SHALL make a new duty value take effect immediately, with no wait for the period boundary.
REQ-024 SHALL derive blink phase from the MSB of a free-running NB_BLINK-bit prescaler.
REQ-025 SHALL drive o_leds[i] = blink_en[i] ? (led_val[i] & phase) : led_val[i], registered.
REQ-026 SHALL pass each switch through a 2-FF synchroniser, then a per-switch counter.
REQ-027 SHALL reset the debounce counter on any mismatch between the synchronised and stable value.
REQ-028 SHALL update the stable value when the synchronised value has differed from it for DEBOUNCE_CYC consecutive cycles.
- Latency from raw change: DEBOUNCE_CYC+2 cycles (+1 register to o_gpi).
REQ-029 SHALL honour every new rising edge of the strobe, including one on the cycle right after the previous command's apply cycle.
REQ-030 SHALL accept no command while the strobe is held high, regardless of duration.

Reset
REQ-031 SHALL, while i_reset is low at a clock edge, clear to 0 all of the following.
- duty, led_val, blink_en.
- Error flag, command count.
- PWM counter, prescaler.
- Debounce counters, stable values.
- o_gpi, o_leds, o_leds_rgb.
REQ-032 SHALL set the strobe-history register to 1 during reset, so a strobe held high across reset release causes no command.
REQ-033 SHALL discard a command in flight when reset is asserted; reset takes priority over every update.

Verification
REQ-034 SHALL pass this case: SET_DUTY ch0 data 64 (NB_PWM=8) -> o_leds_rgb[0] high exactly 64 of every 255 cycles; ack rises 2 cycles after the strobe edge.
REQ-035 SHALL pass this case: duty 0 and duty 255 on ch1/ch2 -> constant 0 and constant 1 over 1000 cycles.
REQ-036 SHALL pass this case: opcode 5, then SET_LED with channel 9 -> o_gpi[30]=1, o_leds unchanged, count=2; CLEAR_ALL -> o_gpi[30]=0.
REQ-037 SHALL pass this case: DEBOUNCE_CYC=8, sw0 bounces at period 3, then holds 1 -> o_gpi[0] stays 0 during the bounce and rises 11 cycles after the last edge.
REQ-038 SHALL pass this case: strobe held high through reset release -> count stays 0; next 0->1 edge -> count=1.
REQ-039 SHALL pass this case: SET_LED ch2=1 plus SET_BLINK ch2=1, NB_BLINK=4 -> o_leds[2] toggles every 8 cycles; reset mid-run -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/gpio_led_ctrl.sv
// GPIO-mapped LED controller: strobed command decode, PWM RGB drive, blinking
// plain LEDs and debounced switches reported back through the status word.
module gpio_led_ctrl #(
    parameter int NB_GPIOS     = 32,
    parameter int N_RGB        = 4,
    parameter int NB_LEDS      = 4,
    parameter int NB_SWITCHES  = 4,
    parameter int NB_PWM       = 8,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int NB_BLINK     = 24
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NB_GPIOS-1:0]    i_gpo,
    output logic [NB_GPIOS-1:0]    o_gpi,
    input  logic [NB_SWITCHES-1:0] i_sw,
    output logic [3*N_RGB-1:0]     o_leds_rgb,
    output logic [NB_LEDS-1:0]     o_leds
);

    localparam int N_CH = 3 * N_RGB;
    localparam int DB_W = $clog2(DEBOUNCE_CYC);
    localparam logic [NB_PWM-1:0] PWM_TOP = {{(NB_PWM-1){1'b1}}, 1'b0};

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_SET_DUTY  = 3'd1;
    localparam logic [2:0] OP_SET_LED   = 3'd2;
    localparam logic [2:0] OP_SET_BLINK = 3'd3;
    localparam logic [2:0] OP_CLEAR     = 3'd4;

    function automatic logic cmd_ok(input logic [2:0] op, input logic [3:0] ch);
        case (op)
            OP_NOP, OP_CLEAR:         cmd_ok = 1'b1;
            OP_SET_DUTY:              cmd_ok = (int'(ch) < N_CH);
            OP_SET_LED, OP_SET_BLINK: cmd_ok = (int'(ch) < NB_LEDS);
            default:                  cmd_ok = 1'b0;
        endcase
    endfunction

    logic                   strobe_q;
    logic                   vld_p0;
    logic [2:0]             op_p0;
    logic [3:0]             ch_p0;
    logic [NB_PWM-1:0]      data_p0;
    logic [NB_PWM-1:0]      duty [N_CH];
    logic [NB_LEDS-1:0]     led_val;
    logic [NB_LEDS-1:0]     blink_en;
    logic                   err_q, err_nxt;
    logic [7:0]             cmd_cnt_q, cnt_nxt;
    logic [NB_GPIOS-1:0]    gpi_nxt;
    logic [NB_PWM-1:0]      pwm_cnt;
    logic [NB_BLINK-1:0]    presc;
    logic [NB_SWITCHES-1:0] sw_meta, sw_sync, sw_stable;
    logic [DB_W-1:0]        db_cnt [NB_SWITCHES];
    logic                   unused_gpo;

    assign unused_gpo = ^i_gpo;

    // Stage p0: strobe edge detect; history resets high so a held strobe is ignored
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            strobe_q <= 1'b1;
            vld_p0   <= 1'b0;
        end else begin
            strobe_q <= i_gpo[31];
            vld_p0   <= i_gpo[31] & ~strobe_q;
        end
    end

    always_ff @(posedge i_clk) begin
        op_p0   <= i_gpo[30:28];
        ch_p0   <= i_gpo[27:24];
        data_p0 <= i_gpo[NB_PWM-1:0];
    end

    always_comb begin
        err_nxt = err_q;
        cnt_nxt = cmd_cnt_q;
        if (vld_p0) begin
            cnt_nxt = cmd_cnt_q + 8'd1;
            if (op_p0 == OP_CLEAR)
                err_nxt = 1'b0;
            else if (!cmd_ok(op_p0, ch_p0))
                err_nxt = 1'b1;
        end
    end

    // Stage p1: apply command to LED state and status counters
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < N_CH; i++) duty[i] <= '0;
            led_val   <= '0;
            blink_en  <= '0;
            err_q     <= 1'b0;
            cmd_cnt_q <= 8'd0;
        end else begin
            err_q     <= err_nxt;
            cmd_cnt_q <= cnt_nxt;
            if (vld_p0 && cmd_ok(op_p0, ch_p0)) begin
                case (op_p0)
                    OP_SET_DUTY:
                        for (int i = 0; i < N_CH; i++)
                            if (ch_p0 == 4'(i)) duty[i] <= data_p0;
                    OP_SET_LED:
                        for (int i = 0; i < NB_LEDS; i++)
                            if (ch_p0 == 4'(i)) led_val[i] <= data_p0[0];
                    OP_SET_BLINK:
                        for (int i = 0; i < NB_LEDS; i++)
                            if (ch_p0 == 4'(i)) blink_en[i] <= data_p0[0];
                    OP_CLEAR: begin
                        for (int i = 0; i < N_CH; i++) duty[i] <= '0;
                        led_val  <= '0;
                        blink_en <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        gpi_nxt                    = '0;
        gpi_nxt[31]                = strobe_q;
        gpi_nxt[30]                = err_nxt;
        gpi_nxt[23:16]             = cnt_nxt;
        gpi_nxt[NB_SWITCHES-1:0]   = sw_stable;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) o_gpi <= '0;
        else          o_gpi <= gpi_nxt;
    end

    // Output stage: PWM compare and blink gating, both registered
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            pwm_cnt    <= '0;
            presc      <= '0;
            o_leds_rgb <= '0;
            o_leds     <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_TOP) ? '0 : pwm_cnt + NB_PWM'(1);
            presc   <= presc + NB_BLINK'(1);
            for (int i = 0; i < N_CH; i++)
                o_leds_rgb[i] <= (pwm_cnt < duty[i]);
            o_leds <= led_val & ~(blink_en & ~{NB_LEDS{presc[NB_BLINK-1]}});
        end
    end

    // Switch path: two-flop synchroniser, then per-switch stability counter
    always_ff @(posedge i_clk) begin
        sw_meta <= i_sw;
        sw_sync <= sw_meta;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sw_stable <= '0;
            for (int i = 0; i < NB_SWITCHES; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB_SWITCHES; i++) begin
                if (sw_sync[i] == sw_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    sw_stable[i] <= sw_sync[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

endmodule
